// File: rtl/fft_frame_ctrl.sv
// Frames free-running ADC samples into FFT_PTS-point sop/eop bursts for the FFT sink and tracks the FFT source side.
// Optional build macro ADC_OFFSET_BINARY_EN: inverts the sample MSB (offset-binary to two's complement).
module fft_frame_ctrl #(
  parameter int FFT_PTS    = 256,
  parameter int PTS_W      = 9,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clr_status,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              fft_sink_valid,
  input  logic              fft_sink_ready,
  output logic              fft_sink_sop,
  output logic              fft_sink_eop,
  output logic [DATA_W-1:0] fft_sink_real,
  output logic [DATA_W-1:0] fft_sink_imag,
  output logic [1:0]        fft_sink_error,
  output logic [PTS_W-1:0]  fft_fftpts,
  output logic              fft_inverse,
  input  logic              fft_source_valid,
  output logic              fft_source_ready,
  input  logic              fft_source_sop,
  input  logic              fft_source_eop,
  input  logic [1:0]        fft_source_error,
  input  logic              out_ready,
  output logic [PTS_W-1:0]  out_bin,
  output logic [15:0]       frames_sent,
  output logic [15:0]       frames_done,
  output logic              ovf_sticky,
  output logic              err_sticky
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(FFT_PTS);
  localparam logic [CW-1:0]    PTS_CNT   = CW'(FFT_PTS);
  localparam logic [CW-1:0]    DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]    P_LAST    = PW'(FFT_PTS - 1);
  localparam logic [PTS_W-1:0] BIN_LAST  = PTS_W'(FFT_PTS - 1);
`ifdef ADC_OFFSET_BINARY_EN
  localparam bit INV_MSB = 1'b1;
`else
  localparam bit INV_MSB = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t            state_reg;
  logic [PW-1:0]     p_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_next;
  logic [CW-1:0]     count_reg;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] head_reg;
  logic              full;
  logic              do_write;
  logic              do_read;
  logic              sink_valid_w;

  logic              in_frame_reg;
  logic              beat;
  logic [PTS_W-1:0]  bin_calc;
  logic              src_fault;

  assign sink_valid_w = (state_reg == STREAM);
  assign full         = (count_reg == DEPTH_CNT);
  assign do_write     = adc_valid && !full;
  assign do_read      = sink_valid_w && fft_sink_ready;
  assign rd_ptr_next  = rd_ptr_reg + AW'(do_read);

  // Registered-read RAM; head_reg always holds the word at the next read pointer,
  // with a bypass when that word is being written this very cycle.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg] <= adc_data;
    if (do_write && (wr_ptr_reg == rd_ptr_next)) head_reg <= adc_data;
    else head_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      if (do_write && !do_read) count_reg <= count_reg + 1'b1;
      else if (!do_write && do_read) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      p_reg       <= '0;
      frames_sent <= '0;
    end else begin
      if (clr_status) frames_sent <= '0;
      case (state_reg)
        IDLE: if (enable) state_reg <= WAIT;
        WAIT: begin
          if (!enable) state_reg <= IDLE;
          else if (count_reg >= PTS_CNT) begin
            state_reg <= STREAM;
            p_reg     <= '0;
          end
        end
        STREAM: begin
          if (fft_sink_ready) begin
            if (p_reg == P_LAST) begin
              // A completed frame wins over a coincident clear.
              frames_sent <= clr_status ? 16'd1 : frames_sent + 16'd1;
              state_reg   <= enable ? WAIT : IDLE;
              p_reg       <= '0;
            end else begin
              p_reg <= p_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fft_sink_valid = sink_valid_w;
  assign fft_sink_sop   = sink_valid_w && (p_reg == '0);
  assign fft_sink_eop   = sink_valid_w && (p_reg == P_LAST);
  assign fft_sink_imag  = '0;
  assign fft_sink_error = '0;
  assign fft_fftpts     = PTS_W'(FFT_PTS);
  assign fft_inverse    = 1'b0;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_real
    assign fft_sink_real[gi] = sink_valid_w & (head_reg[gi] ^ (INV_MSB && (gi == DATA_W - 1)));
  end

  assign fft_source_ready = out_ready;
  assign beat      = fft_source_valid && out_ready;
  assign bin_calc  = fft_source_sop ? '0 : out_bin + 1'b1;
  assign src_fault = beat && ((fft_source_error != 2'b00) ||
                              (fft_source_sop && in_frame_reg) ||
                              (fft_source_eop && (bin_calc != BIN_LAST)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_bin      <= '0;
      in_frame_reg <= 1'b0;
      frames_done  <= '0;
      ovf_sticky   <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      if (beat) begin
        out_bin <= bin_calc;
        if (fft_source_eop) in_frame_reg <= 1'b0;
        else if (fft_source_sop) in_frame_reg <= 1'b1;
      end
      if (beat && fft_source_eop) frames_done <= clr_status ? 16'd1 : frames_done + 16'd1;
      else if (clr_status) frames_done <= '0;
      if (adc_valid && full) ovf_sticky <= 1'b1;
      else if (clr_status) ovf_sticky <= 1'b0;
      if (src_fault) err_sticky <= 1'b1;
      else if (clr_status) err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with FFT_PTS=8, FIFO_DEPTH=16.
module tb_fft_frame_ctrl;
  localparam int PTS = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n, enable, clr_status, adc_valid;
  logic [7:0] adc_data;
  logic fft_sink_valid, fft_sink_ready, fft_sink_sop, fft_sink_eop;
  logic [7:0] fft_sink_real, fft_sink_imag;
  logic [1:0] fft_sink_error;
  logic [8:0] fft_fftpts;
  logic fft_inverse;
  logic fft_source_valid, fft_source_ready, fft_source_sop, fft_source_eop;
  logic [1:0] fft_source_error;
  logic out_ready;
  logic [8:0] out_bin;
  logic [15:0] frames_sent, frames_done;
  logic ovf_sticky, err_sticky;

  fft_frame_ctrl #(.FFT_PTS(PTS), .PTS_W(9), .DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clr_status(clr_status),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
    .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_sink_real(fft_sink_real), .fft_sink_imag(fft_sink_imag),
    .fft_sink_error(fft_sink_error), .fft_fftpts(fft_fftpts), .fft_inverse(fft_inverse),
    .fft_source_valid(fft_source_valid), .fft_source_ready(fft_source_ready),
    .fft_source_sop(fft_source_sop), .fft_source_eop(fft_source_eop),
    .fft_source_error(fft_source_error), .out_ready(out_ready), .out_bin(out_bin),
    .frames_sent(frames_sent), .frames_done(frames_done),
    .ovf_sticky(ovf_sticky), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t sink_q[$];
  int    bin_q[$];
  int    errors = 0;
  int    checks = 0;
  int    xfer_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else
      $display("ok   %s = %0d", name, act);
  endtask

  task automatic push_beats(input int start, input int n, input bit last_is_eop);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = 8'(start + i);
`ifdef ADC_OFFSET_BINARY_EN
      b.d = b.d ^ 8'h80;
`endif
      b.sop = (i == 0);
      b.eop = last_is_eop && (i == PTS - 1);
      sink_q.push_back(b);
    end
  endtask

  task automatic write_samples(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = 8'(start + i);
      @(posedge clk); #1;
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_sent(input int target, input int budget);
    for (int n = 0; n < budget && frames_sent != 16'(target); n++) begin
      @(posedge clk); #1;
    end
    check("frames_sent_wait", int'(frames_sent), target);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n;
    for (n = 0; n < budget && xfer_cnt < target; n++) begin
      @(posedge clk); #1;
    end
    if (xfer_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL xfer_wait actual=%0d expected=%0d", xfer_cnt, target);
    end
  endtask

  // Drives one source frame: nbeats beats, eop on the last, optional error on one beat,
  // optional out_ready stall cycle before each beat.
  task automatic src_frame(input int nbeats, input int err_at, input bit stall);
    for (int i = 0; i < nbeats; i++) begin
      fft_source_valid = 1'b1;
      fft_source_sop   = (i == 0);
      fft_source_eop   = (i == nbeats - 1);
      fft_source_error = (i == err_at) ? 2'b01 : 2'b00;
      if (stall) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      bin_q.push_back(i);
      @(posedge clk); #1;
    end
    fft_source_valid = 1'b0;
    fft_source_sop   = 1'b0;
    fft_source_eop   = 1'b0;
    fft_source_error = 2'b00;
  endtask

  // Sink monitor: pops on every transfer; also checks that a stalled beat is held.
  beat_t held;
  bit    stall_prev = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (reset_n && stall_prev && fft_sink_valid) begin
      checks++;
      if ({fft_sink_real, fft_sink_sop, fft_sink_eop} != held) begin
        errors++;
        $display("FAIL sink_hold actual=%h/%b/%b expected=%h/%b/%b",
                 fft_sink_real, fft_sink_sop, fft_sink_eop, held.d, held.sop, held.eop);
      end
    end
    stall_prev = reset_n && fft_sink_valid && !fft_sink_ready;
    held = {fft_sink_real, fft_sink_sop, fft_sink_eop};
    if (reset_n && fft_sink_valid && fft_sink_ready) begin
      xfer_cnt++;
      checks++;
      if (sink_q.size() == 0) begin
        errors++;
        $display("FAIL sink_beat unexpected actual=%h/%b/%b expected=none",
                 fft_sink_real, fft_sink_sop, fft_sink_eop);
      end else begin
        e = sink_q.pop_front();
        if ({fft_sink_real, fft_sink_sop, fft_sink_eop} != e) begin
          errors++;
          $display("FAIL sink_beat actual=%h/%b/%b expected=%h/%b/%b",
                   fft_sink_real, fft_sink_sop, fft_sink_eop, e.d, e.sop, e.eop);
        end else
          $display("beat data=%h sop=%b eop=%b", fft_sink_real, fft_sink_sop, fft_sink_eop);
      end
    end
  end

  // Source monitor: out_bin after each accepted beat must equal the expected bin.
  always begin
    int eb;
    @(negedge clk);
    if (reset_n && fft_source_valid && out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (bin_q.size() == 0) begin
        errors++;
        $display("FAIL out_bin unexpected actual=%0d expected=none", out_bin);
      end else begin
        eb = bin_q.pop_front();
        if (int'(out_bin) != eb) begin
          errors++;
          $display("FAIL out_bin actual=%0d expected=%0d", out_bin, eb);
        end else
          $display("bin %0d", out_bin);
      end
    end
  end

  initial begin
    int base;
    reset_n = 1'b0; enable = 1'b0; clr_status = 1'b0; adc_valid = 1'b0; adc_data = '0;
    fft_sink_ready = 1'b1; fft_source_valid = 1'b0; fft_source_sop = 1'b0;
    fft_source_eop = 1'b0; fft_source_error = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sink_valid", int'(fft_sink_valid), 0);
    check("rst_frames_sent", int'(frames_sent), 0);
    check("rst_frames_done", int'(frames_done), 0);
    check("rst_stickies", int'({ovf_sticky, err_sticky}), 0);
    check("rst_out_bin", int'(out_bin), 0);
    check("fftpts", int'(fft_fftpts), PTS);
    check("source_ready_follows", int'(fft_source_ready), 1);
    reset_n = 1'b1;

    // Basic frame, sink always ready.
    enable = 1'b1;
    push_beats(0, PTS, 1'b1);
    write_samples(0, PTS);
    check("valid_low_at_8th_write", int'(fft_sink_valid), 0);
    @(posedge clk); #1;
    check("valid_rises_next", int'(fft_sink_valid), 1);
    wait_sent(1, 40);

    // Toggling sink_ready.
    fft_sink_ready = 1'b0;
    push_beats(8, PTS, 1'b1);
    write_samples(8, PTS);
    for (int n = 0; n < 60 && frames_sent != 16'd2; n++) begin
      fft_sink_ready = !fft_sink_ready;
      @(posedge clk); #1;
    end
    check("frames_sent_toggle", int'(frames_sent), 2);
    fft_sink_ready = 1'b0;

    // enable drops after 3rd transfer; FIFO keeps 8 more samples.
    push_beats(16, PTS, 1'b1);
    write_samples(16, 2 * PTS);
    base = xfer_cnt;
    fft_sink_ready = 1'b1;
    wait_xfers(base + 3, 40);
    enable = 1'b0;
    wait_sent(3, 40);
    repeat (12) @(posedge clk);
    #1;
    check("no_new_frame_xfers", xfer_cnt - base, PTS);
    check("idle_sink_valid", int'(fft_sink_valid), 0);

    // Overflow: fill to 16, drop the 17th, clear coincident with another drop.
    write_samples(32, PTS);
    check("ovf_clear_when_full", int'(ovf_sticky), 0);
    write_samples(40, 1);
    check("ovf_set", int'(ovf_sticky), 1);
    clr_status = 1'b1;
    write_samples(41, 1);
    check("ovf_event_wins_clr", int'(ovf_sticky), 1);
    @(posedge clk); #1;
    clr_status = 1'b0;
    check("ovf_cleared", int'(ovf_sticky), 0);
    check("frames_sent_cleared", int'(frames_sent), 0);
    push_beats(24, PTS, 1'b1);
    push_beats(32, PTS, 1'b1);
    enable = 1'b1;
    wait_sent(2, 80);

    // Source side: short frame, then clean frame with stalls, then error beat.
    src_frame(6, -1, 1'b0);
    check("short_frame_err", int'(err_sticky), 1);
    check("short_frame_done", int'(frames_done), 1);
    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
    check("err_cleared", int'(err_sticky), 0);
    check("frames_done_cleared", int'(frames_done), 0);
    src_frame(PTS, -1, 1'b1);
    check("clean_frame_err", int'(err_sticky), 0);
    check("clean_frame_done", int'(frames_done), 1);
    out_ready = 1'b0;
    #1;
    check("source_ready_low", int'(fft_source_ready), 0);
    src_frame(PTS, 3, 1'b0);
    check("error_beat_err", int'(err_sticky), 1);
    check("frames_done_two", int'(frames_done), 2);

    // Reset mid-frame at p=4.
    push_beats(50, 4, 1'b0);
    write_samples(50, PTS);
    base = xfer_cnt;
    wait_xfers(base + 4, 40);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_sink_valid", int'(fft_sink_valid), 0);
    check("mid_rst_frames_sent", int'(frames_sent), 0);
    check("mid_rst_frames_done", int'(frames_done), 0);
    check("mid_rst_err", int'(err_sticky), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_beats(60, PTS, 1'b1);
    write_samples(60, PTS);
    wait_sent(1, 40);
    repeat (4) @(posedge clk);
    #1;
    check("sink_queue_drained", sink_q.size(), 0);
    check("bin_queue_drained", bin_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Sequences ADC audio samples into the FFT core's streaming interface for the speech front end. Buffers free-running ADC samples in an internal FIFO and releases them as complete FFT_PTS-point frames with sop/eop framing, honouring sink backpressure. Monitors the FFT source side: bin indexing, frame integrity and sticky status for the downstream feature stage.

Parameters:
FFT_PTS, 256, points per frame; power of 2, 8..256
PTS_W, 9, width of fftpts and bin index
DATA_W, 8, ADC sample width
FIFO_DEPTH, 512, sample FIFO depth; power of 2, >= FFT_PTS

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
enable  in  1  start new frames while high
clr_status  in  1  clears sticky flags and counters
adc_valid  in  1  one-cycle sample strobe, no backpressure
adc_data  in  DATA_W  ADC sample
fft_sink_valid  out  1  frame data valid to FFT
fft_sink_ready  in  1  FFT accepts data
fft_sink_sop  out  1  first point of frame
fft_sink_eop  out  1  last point of frame
fft_sink_real  out  DATA_W  sample to FFT
fft_sink_imag  out  DATA_W  constant 0
fft_sink_error  out  2  constant 0
fft_fftpts  out  PTS_W  constant FFT_PTS
fft_inverse  out  1  constant 0
fft_source_valid  in  1  FFT output valid
fft_source_ready  out  1  equals out_ready
fft_source_sop  in  1  FFT output sop
fft_source_eop  in  1  FFT output eop
fft_source_error  in  2  FFT output error
out_ready  in  1  downstream ready
out_bin  out  PTS_W  bin index of current source beat
frames_sent  out  16  frames fully delivered to FFT, wraps
frames_done  out  16  frames received from FFT, wraps
ovf_sticky  out  1  sample dropped on full FIFO
err_sticky  out  1  FFT output error or framing fault

Behaviour:
- Reset (reset_n low at clk edge): FIFO empty, state IDLE, all outputs 0 except constants (fftpts=FFT_PTS); counters, bin, stickies 0. Reset mid-frame aborts the frame; no eop issued.
- Sample transfer to FFT: cycle with fft_sink_valid & fft_sink_ready. Write: adc_valid & !full.
- FIFO: first-word-fall-through; fft_sink_real = head word, stable while valid & !ready. Simultaneous write+read: count unchanged. adc_valid when full: sample dropped, ovf_sticky set.
- FSM states IDLE, WAIT, STREAM:
  IDLE -> WAIT when enable=1.
  WAIT -> STREAM when count >= FFT_PTS; point counter p := 0. WAIT -> IDLE if enable=0.
  STREAM: fft_sink_valid=1 (registered state; asserted cycle after count >= FFT_PTS sampled). sop = (p==0), eop = (p==FFT_PTS-1). p increments per transfer. Eop transfer: frames_sent++, go WAIT (enable=1) or IDLE (enable=0).
  enable dropping mid-frame never truncates; frame completes.
- Stall: fft_sink_ready low holds p, data, sop/eop unchanged; no timeout.
- Source side: fft_source_ready = out_ready combinationally. Beat = fft_source_valid & out_ready. out_bin = 0 on sop beat, else previous+1; out_bin registered, reflects last beat.
- Eop beat: frames_done++. err_sticky set if eop beat with computed bin != FFT_PTS-1, sop beat while mid-frame, or any beat with fft_source_error != 0.
- clr_status: clears stickies, frames_sent, frames_done next edge; does not affect FIFO/FSM. If event coincides with clr_status, event wins (flag set, counter = 1).
- Counters wrap 0xFFFF -> 0.

Optional Feature:
ADC_OFFSET_BINARY_EN: defined -> fft_sink_real = head word with MSB inverted (offset-binary ADC to two's complement, 0x80 -> 0x00, 0x00 -> 0x80). Undefined -> head word passed unchanged.

Test Plan:
- FFT_PTS=8, enable=1, 8 adc_valid samples 0..7, sink_ready=1 -> sink_valid rises cycle after 8th write; 8 beats, sop on 0, eop on 7, frames_sent=1.
- Same, sink_ready toggles 1/0 per cycle -> data/sop/eop held on stalls, 8 transfers total, order 0..7, no duplicates.
- FIFO_DEPTH=16, enable=0, 17 samples -> 17th dropped, ovf_sticky=1; clr_status -> ovf_sticky=0, FIFO still holds 16.
- enable drops after 3rd transfer of frame -> remaining 5 transfers complete with eop, FSM returns IDLE, no new sop though FIFO holds 8+.
- Source beats sop..eop with eop on 6th beat (FFT_PTS=8) -> err_sticky=1, frames_done=1; clean 8-beat frame with out_ready stalls -> out_bin 0..7, err_sticky stays 0.
- reset_n low mid-frame at p=4 -> next cycle sink_valid=0, counters 0; after reset, new frame begins with sop on fresh samples.
